mem_arbiter: RTL

Two-requester arbiter sharing the single-port synchronous video/system RAM between the core and the VGA controller. It sits between those two requesters and the memory controller's RAM port. It issues at most one access per cycle through a fixed 2-stage pipeline. The VGA (read-only) has priority, with a bounded starvation guarantee for the core.

---
 rtl/mem_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between a read-only VGA port
// and the core, VGA first, with the core guaranteed a slot after VGA_BURST_MAX VGA grants.
module mem_arbiter #(
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 16,
    parameter int VGA_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int RUN_W = $clog2(VGA_BURST_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VGA_BURST_MAX);

    typedef enum logic [1:0] {IDLE, VGA, CORE_RD, CORE_WR} owner_e;

    owner_e            state_q, state_d, tag_q;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic              vga_valid_q, core_done_q;
    logic              vga_win, core_win;

    always_comb begin
        vga_win      = vga_req && !(core_req && run_q == RUN_MAX);
        core_win     = core_req && !vga_win;
        vga_gnt      = !reset && vga_win;
        core_gnt     = !reset && core_win;
        state_d      = vga_gnt ? VGA : core_gnt ? (core_we ? CORE_WR : CORE_RD) : IDLE;
        // run counts VGA wins only while the core is actually waiting
        run_d        = (core_gnt || !core_req) ? '0
                     : (vga_gnt && run_q != RUN_MAX) ? run_q + 1'b1 : run_q;
        mem_addr_d   = vga_gnt ? vga_addr : core_gnt ? core_addr : mem_addr_q;
        mem_wdata_d  = (core_gnt && core_we) ? core_wdata : mem_wdata_q;
        vga_data_d   = (tag_q == VGA) ? mem_rdata : vga_data_q;
        core_rdata_d = (tag_q == CORE_RD) ? mem_rdata : core_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tag_q        <= IDLE;
            run_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            vga_data_q   <= '0;
            core_rdata_q <= '0;
            vga_valid_q  <= 1'b0;
            core_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= state_q;
            run_q        <= run_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            vga_data_q   <= vga_data_d;
            core_rdata_q <= core_rdata_d;
            vga_valid_q  <= tag_q == VGA;
            core_done_q  <= tag_q == CORE_RD || tag_q == CORE_WR;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = state_q == CORE_WR;
    assign vga_data   = vga_data_q;
    assign vga_valid  = vga_valid_q;
    assign core_rdata = core_rdata_q;
    assign core_done  = core_done_q;
endmodule
